// File: rtl/c2s_mwr_chan.sv
// Card-to-system DMA write channel: buffers an app stream in a local FIFO
// and drains it as MWr bursts, then posts a status qword and an interrupt.
module c2s_mwr_chan #(
    parameter int CHAN_NUM             = 0,
    parameter int PCIE_CORE_DATA_WIDTH = 128,
    parameter int FIFO_DEPTH_LOG2      = 6
) (
    input  logic                              s_axi_clk,
    input  logic                              s_axi_rst,
    input  logic                              bm_start,
    input  logic                              bm_stop,
    input  logic [63:0]                       bm_req_address,
    input  logic [31:0]                       bm_xfer_len,
    input  logic [63:0]                       bm_status_address,
    input  logic [12:0]                       max_payload_size,
    output logic                              state_o,
    input  logic [PCIE_CORE_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [PCIE_CORE_DATA_WIDTH/32-1:0] s_axis_tkeep,
    input  logic                              s_axis_tlast,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    output logic                              mwr_req_arbit_req,
    input  logic                              mwr_req_arbit_grnt,
    output logic [12:0]                       mwr_req_burst_len_out,
    output logic [63:0]                       mwr_req_burst_sys_addr_out,
    output logic [31:0]                       mwr_req_context,
    output logic [PCIE_CORE_DATA_WIDTH-1:0]   bm_tx_data,
    output logic                              bm_tx_data_valid,
    input  logic                              bm_tx_data_rdy,
    output logic                              bm_tx_last,
    output logic                              status_req,
    input  logic                              status_ack,
    output logic [63:0]                       status_qword,
    output logic [63:0]                       status_addr,
    output logic                              int_gen
);
    localparam int DW = PCIE_CORE_DATA_WIDTH;
    localparam int BB = DW / 8;
    localparam int BL = $clog2(BB);
    localparam int KW = DW / 32;
    localparam int FL = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << FL;
    localparam logic [31:0] CAP = 32'(DEPTH * BB);
    localparam logic [31:0] BB32 = 32'(BB);
    localparam logic [12:0] BB13 = 13'(BB);

    typedef enum logic [2:0] {IDLE, FILL, ARB, XFER, STATUS, INT} state_t;

    state_t      state;
    logic [63:0] addr;
    logic [31:0] remaining, written, beats_in, beats_max;
    logic        done_flag, stop_flag, tlast_seen;
    logic [12:0] mps, burst_len, burst_left;

    logic [DW-1:0] mem [DEPTH];
    logic [FL-1:0] wr_ptr, rd_ptr;
    logic [FL:0]   cnt;
    logic [31:0]   fifo_bytes;

    logic        in_done, push, pop, flush, is_last, ready_b, tl_now;
    logic [31:0] in_bytes, target, b4k;
    logic [12:0] len_next, beat_bytes;

    assign in_done = done_flag || (beats_in == beats_max);
    assign state_o = (state != IDLE);
    assign s_axis_tready = state_o && (cnt != DEPTH[FL:0]) && !in_done;
    assign push = s_axis_tvalid && s_axis_tready;
    assign tl_now = tlast_seen || (push && s_axis_tlast);

    assign bm_tx_data_valid = (state == XFER) && (cnt != '0);
    assign pop = bm_tx_data_valid && bm_tx_data_rdy;
    assign is_last = (burst_left <= BB13);
    assign bm_tx_last = bm_tx_data_valid && is_last;
    assign bm_tx_data = bm_tx_data_valid ? mem[rd_ptr] : '0;
    assign beat_bytes = (burst_left < BB13) ? burst_left : BB13;

    // A tlast beat only carries the dwords flagged in tkeep
    always_comb begin
        in_bytes = BB32;
        if (s_axis_tlast) begin
            in_bytes = '0;
            for (int i = 0; i < KW; i++)
                if (s_axis_tkeep[i]) in_bytes = in_bytes + 32'd4;
        end
    end

    always_comb begin
        b4k = 32'd4096 - {20'd0, addr[11:0]};
        target = {19'd0, mps};
        if (b4k < target) target = b4k;
        if (remaining < target) target = remaining;
        if (CAP < target) target = CAP;
    end

    assign len_next = (fifo_bytes < target) ? fifo_bytes[12:0] : target[12:0];
    assign ready_b = (fifo_bytes != '0) && ((fifo_bytes >= target) || in_done);

    assign flush = (state == IDLE)
                || (bm_stop && (state == FILL))
                || (bm_stop && (state == ARB) && !mwr_req_arbit_grnt)
                || (pop && is_last && (stop_flag || bm_stop));

    always_ff @(posedge s_axi_clk) begin
        if (push) mem[wr_ptr] <= s_axis_tdata;
    end

    always_ff @(posedge s_axi_clk or posedge s_axi_rst) begin
        if (s_axi_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            fifo_bytes <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            fifo_bytes <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + {{FL{1'b0}}, push} - {{FL{1'b0}}, pop};
            fifo_bytes <= fifo_bytes + (push ? in_bytes : 32'd0)
                        - (pop ? {19'd0, beat_bytes} : 32'd0);
        end
    end

    always_ff @(posedge s_axi_clk or posedge s_axi_rst) begin
        if (s_axi_rst) begin
            state                      <= IDLE;
            addr                       <= '0;
            remaining                  <= '0;
            written                    <= '0;
            beats_in                   <= '0;
            beats_max                  <= '0;
            done_flag                  <= 1'b0;
            stop_flag                  <= 1'b0;
            tlast_seen                 <= 1'b0;
            mps                        <= '0;
            burst_len                  <= '0;
            burst_left                 <= '0;
            mwr_req_arbit_req          <= 1'b0;
            mwr_req_burst_len_out      <= '0;
            mwr_req_burst_sys_addr_out <= '0;
            mwr_req_context            <= '0;
            status_req                 <= 1'b0;
            status_qword               <= '0;
            status_addr                <= '0;
            int_gen                    <= 1'b0;
        end else begin
            if (push) begin
                beats_in <= beats_in + 32'd1;
                if (s_axis_tlast) begin
                    done_flag  <= 1'b1;
                    tlast_seen <= 1'b1;
                end
            end
            unique case (state)
                IDLE: if (bm_start) begin
                    state       <= FILL;
                    addr        <= bm_req_address & ~64'(BB - 1);
                    remaining   <= bm_xfer_len;
                    beats_max   <= bm_xfer_len >> BL;
                    written     <= '0;
                    beats_in    <= '0;
                    done_flag   <= 1'b0;
                    stop_flag   <= 1'b0;
                    tlast_seen  <= 1'b0;
                    mps         <= max_payload_size;
                    status_addr <= bm_status_address;
                end
                FILL: if (bm_stop) begin
                    state        <= STATUS;
                    stop_flag    <= 1'b1;
                    done_flag    <= 1'b1;
                    status_req   <= 1'b1;
                    status_qword <= {1'b1, tl_now, 30'd0, written};
                end else if (in_done && fifo_bytes == '0) begin
                    state        <= STATUS;
                    status_req   <= 1'b1;
                    status_qword <= {stop_flag, tl_now, 30'd0, written};
                end else if (ready_b) begin
                    state                      <= ARB;
                    mwr_req_arbit_req          <= 1'b1;
                    burst_len                  <= len_next;
                    burst_left                 <= len_next;
                    mwr_req_burst_len_out      <= len_next;
                    mwr_req_burst_sys_addr_out <= addr;
                    mwr_req_context            <= {24'd0, 8'(CHAN_NUM)};
                end
                ARB: if (mwr_req_arbit_grnt) begin
                    state             <= XFER;
                    mwr_req_arbit_req <= 1'b0;
                end else if (bm_stop) begin
                    state                      <= STATUS;
                    mwr_req_arbit_req          <= 1'b0;
                    mwr_req_burst_len_out      <= '0;
                    mwr_req_burst_sys_addr_out <= '0;
                    mwr_req_context            <= '0;
                    stop_flag                  <= 1'b1;
                    done_flag                  <= 1'b1;
                    status_req                 <= 1'b1;
                    status_qword <= {1'b1, tl_now, 30'd0, written};
                end
                XFER: begin
                    // Stop never cuts a burst short; it is honoured after the last beat
                    if (bm_stop) begin
                        stop_flag <= 1'b1;
                        done_flag <= 1'b1;
                    end
                    if (pop) begin
                        burst_left <= burst_left - beat_bytes;
                        if (is_last) begin
                            addr      <= addr + {51'd0, burst_len};
                            remaining <= remaining - {19'd0, burst_len};
                            written   <= written + {19'd0, burst_len};
                            mwr_req_burst_len_out      <= '0;
                            mwr_req_burst_sys_addr_out <= '0;
                            mwr_req_context            <= '0;
                            if (stop_flag || bm_stop) begin
                                state        <= STATUS;
                                status_req   <= 1'b1;
                                status_qword <= {1'b1, tl_now, 30'd0,
                                                 written + {19'd0, burst_len}};
                            end else begin
                                state <= FILL;
                            end
                        end
                    end
                end
                STATUS: if (status_ack) begin
                    state      <= INT;
                    status_req <= 1'b0;
                    int_gen    <= 1'b1;
                end
                INT: begin
                    int_gen <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_c2s_mwr_chan.sv
// Randomized bench for c2s_mwr_chan: burst splitting, data order, status
// writeback, stop and reset behaviour against a byte-level reference model.
module tb_c2s_mwr_chan;
    localparam int DW = 128;
    localparam int BB = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bm_start = 0, bm_stop = 0;
    logic [63:0]   bm_req_address = '0, bm_status_address = '0;
    logic [31:0]   bm_xfer_len = '0;
    logic [12:0]   max_payload_size = 13'd256;
    logic          state_o;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [3:0]    s_axis_tkeep = '0;
    logic          s_axis_tlast = 0, s_axis_tvalid = 0, s_axis_tready;
    logic          mwr_req_arbit_req, mwr_req_arbit_grnt = 0;
    logic [12:0]   mwr_req_burst_len_out;
    logic [63:0]   mwr_req_burst_sys_addr_out;
    logic [31:0]   mwr_req_context;
    logic [DW-1:0] bm_tx_data;
    logic          bm_tx_data_valid, bm_tx_data_rdy = 0, bm_tx_last;
    logic          status_req, status_ack = 0;
    logic [63:0]   status_qword, status_addr;
    logic          int_gen;

    always #5 clk = ~clk;

    c2s_mwr_chan #(
        .CHAN_NUM(5), .PCIE_CORE_DATA_WIDTH(DW), .FIFO_DEPTH_LOG2(6)
    ) dut (
        .s_axi_clk(clk), .s_axi_rst(rst),
        .bm_start(bm_start), .bm_stop(bm_stop),
        .bm_req_address(bm_req_address), .bm_xfer_len(bm_xfer_len),
        .bm_status_address(bm_status_address),
        .max_payload_size(max_payload_size), .state_o(state_o),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .mwr_req_arbit_req(mwr_req_arbit_req),
        .mwr_req_arbit_grnt(mwr_req_arbit_grnt),
        .mwr_req_burst_len_out(mwr_req_burst_len_out),
        .mwr_req_burst_sys_addr_out(mwr_req_burst_sys_addr_out),
        .mwr_req_context(mwr_req_context),
        .bm_tx_data(bm_tx_data), .bm_tx_data_valid(bm_tx_data_valid),
        .bm_tx_data_rdy(bm_tx_data_rdy), .bm_tx_last(bm_tx_last),
        .status_req(status_req), .status_ack(status_ack),
        .status_qword(status_qword), .status_addr(status_addr),
        .int_gen(int_gen)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [511:0] got,
                         input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Reference model state
    logic [DW-1:0]   exp_q[$];
    longint unsigned m_addr, m_written, m_total, m_mps;
    longint unsigned m_left;
    int              m_occ, bursts, gnt_max;
    bit              m_tlast, exp_stop, xfer_over;
    logic [63:0]     m_saddr;

    function automatic longint unsigned blen(input longint unsigned a,
            input longint unsigned left, input longint unsigned mps);
        longint unsigned el, b;
        el = mps;
        b = 4096 - (a % 4096);
        if (b < el) el = b;
        if (left < el) el = left;
        if (1024 < el) el = 1024;
        return el;
    endfunction

    function automatic int n_bursts(input longint unsigned a,
            input longint unsigned tot, input longint unsigned mps);
        longint unsigned w;
        int n;
        w = 0;
        n = 0;
        while (w < tot) begin
            w += blen(a + w, tot - w, mps);
            n++;
        end
        return n;
    endfunction

    always @(negedge clk) bm_tx_data_rdy = ($urandom_range(1) == 1);

    initial forever begin
        @(negedge clk);
        if (mwr_req_arbit_req && !rst) begin
            repeat ($urandom_range(gnt_max)) @(negedge clk);
            if (mwr_req_arbit_req) begin
                mwr_req_arbit_grnt = 1;
                @(negedge clk);
                mwr_req_arbit_grnt = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (status_req && !rst) begin
            repeat ($urandom_range(5)) @(negedge clk);
            if (status_req) begin
                status_ack = 1;
                @(negedge clk);
                status_ack = 0;
            end
        end
    end

    always @(posedge clk) begin
        logic [DW-1:0]   d;
        logic [63:0]     qw;
        longint unsigned el;
        if (!rst) begin
            if (m_occ >= 64) check("full_tready", s_axis_tready, 0);
            if (s_axis_tvalid && s_axis_tready) begin
                exp_q.push_back(s_axis_tdata);
                m_occ++;
                if (s_axis_tlast) m_tlast = 1;
            end
            if (mwr_req_arbit_grnt && mwr_req_arbit_req) begin
                el = blen(m_addr, m_total - m_written, m_mps);
                check("blen", mwr_req_burst_len_out, el);
                check("baddr", mwr_req_burst_sys_addr_out, m_addr);
                check("ctx", mwr_req_context, 32'd5);
                m_left = el;
                m_addr += el;
                m_written += el;
                bursts++;
            end
            if (bm_tx_data_valid && bm_tx_data_rdy) begin
                if (exp_q.size() == 0) check("underflow", 1, 0);
                else begin
                    d = exp_q.pop_front();
                    check("data", bm_tx_data, d);
                end
                check("last", bm_tx_last, m_left <= BB);
                m_left -= (m_left < BB) ? m_left : BB;
                m_occ--;
            end
            if (status_req && status_ack) begin
                qw = {exp_stop, m_tlast, 30'd0,
                      32'(exp_stop ? m_written : m_total)};
                check("saddr", status_addr, m_saddr);
                check("qword", status_qword, qw);
            end
        end
    end

    task automatic send_stream(input int nb, input int tl, input logic [3:0] k);
        int t;
        for (int i = 0; i < nb && !xfer_over; i++) begin
            @(negedge clk);
            while ($urandom_range(3) == 0 && !xfer_over) begin
                s_axis_tvalid = 0;
                @(negedge clk);
            end
            s_axis_tvalid = 1;
            s_axis_tdata = {$urandom, $urandom, $urandom, $urandom};
            s_axis_tlast = (i == tl);
            s_axis_tkeep = (i == tl) ? k : 4'hF;
            t = 0;
            while (!s_axis_tready && !xfer_over && t < 5000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 5000) check("tmo_send", 0, 1);
        end
        @(negedge clk);
        s_axis_tvalid = 0;
        s_axis_tlast = 0;
    endtask

    task automatic wait_int();
        int t;
        t = 0;
        while (!int_gen && t < 20000) begin
            // start while busy must be ignored
            bm_start = (t == 10 && state_o);
            @(negedge clk);
            t++;
        end
        bm_start = 0;
        if (!int_gen) check("tmo_int", 0, 1);
        else begin
            @(negedge clk);
            check("int_pulse", int_gen, 0);
            check("idle", state_o, 0);
        end
    endtask

    task automatic inject_stop(input int k);
        int t;
        t = 0;
        while (!(bursts == k + 1 && bm_tx_data_valid) && !xfer_over && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (bursts == k + 1 && bm_tx_data_valid) begin
            bm_stop = 1;
            @(negedge clk);
            bm_stop = 0;
        end else check("stop_hit", 0, 1);
    endtask

    task automatic setup(input logic [63:0] a, input int len, input int mps,
                         input longint unsigned tot, input bit stp, input int gm);
        exp_q.delete();
        m_addr = a & ~64'hF;
        m_written = 0;
        m_total = tot;
        m_mps = mps;
        m_left = 0;
        m_occ = 0;
        bursts = 0;
        m_tlast = 0;
        exp_stop = stp;
        m_saddr = {$urandom, $urandom} & ~64'h7;
        xfer_over = 0;
        gnt_max = gm;
        @(negedge clk);
        bm_req_address = a;
        bm_xfer_len = 32'(len);
        max_payload_size = 13'(mps);
        bm_status_address = m_saddr;
        bm_start = 1;
    endtask

    task automatic run_xfer(input logic [63:0] a, input int len, input int mps,
                            input int tl, input logic [3:0] k, input int stop_k,
                            input bit both, input int gm);
        int nb, exp_n;
        longint unsigned tot;
        nb = (tl >= 0) ? tl + 1 : len / BB;
        tot = (tl >= 0) ? longint'(tl * BB + 4 * $countones(k)) : longint'(len);
        exp_n = n_bursts(a & ~64'hF, tot, mps);
        setup(a, len, mps, tot, stop_k >= 0, gm);
        bm_stop = both;
        @(negedge clk);
        bm_start = 0;
        bm_stop = 0;
        fork
            send_stream(nb, tl, k);
            if (stop_k >= 0) inject_stop(stop_k);
            begin
                wait_int();
                xfer_over = 1;
            end
        join
        if (stop_k >= 0) check("nburst_stop", bursts, stop_k + 1);
        else check("nburst", bursts, exp_n);
    endtask

    function automatic logic [511:0] outs();
        return {state_o, s_axis_tready, mwr_req_arbit_req, mwr_req_burst_len_out,
                mwr_req_burst_sys_addr_out, mwr_req_context, bm_tx_data,
                bm_tx_data_valid, bm_tx_last, status_req, status_qword,
                status_addr, int_gen};
    endfunction

    task automatic reset_mid();
        int t;
        setup(64'hA000, 1024, 256, 1024, 0, 2);
        @(negedge clk);
        bm_start = 0;
        fork
            send_stream(64, -1, 4'hF);
            begin
                t = 0;
                while (!bm_tx_data_valid && t < 5000) begin
                    @(negedge clk);
                    t++;
                end
                check("rst_reach_xfer", bm_tx_data_valid, 1);
                #2 rst = 1;
                #1 check("rst_async", outs(), '0);
                xfer_over = 1;
            end
        join
        @(negedge clk);
        check("rst_hold", outs(), '0);
        rst = 0;
    endtask

    initial begin
        int len, tl;
        gnt_max = 2;
        repeat (3) @(negedge clk);
        check("reset_outs", outs(), '0);
        rst = 0;

        run_xfer(64'h1000, 512, 256, -1, 4'h0, -1, 0, 3);
        run_xfer(64'h1F80, 256, 256, -1, 4'h0, -1, 0, 3);
        run_xfer(64'h3000, 1024, 256, 4, 4'b0011, -1, 0, 3);
        run_xfer(64'h4000, 2048, 256, -1, 4'h0, 2, 0, 5);
        run_xfer(64'h5000, 0, 256, -1, 4'h0, -1, 0, 3);
        run_xfer(64'h6FC8, 512, 128, -1, 4'h0, -1, 1, 3);
        run_xfer(64'h8000, 2048, 1024, -1, 4'h0, -1, 0, 60);
        reset_mid();
        run_xfer(64'h9000, 512, 512, -1, 4'h0, -1, 0, 3);

        for (int i = 0; i < 8; i++) begin
            len = 16 * int'($urandom_range(1, 128));
            tl = ($urandom_range(1) == 1) ? int'($urandom_range(len / 16 - 1)) : -1;
            run_xfer({48'd0, 4'($urandom_range(15)), 8'($urandom_range(255)), 4'h0},
                     len, 128 << $urandom_range(5), tl,
                     4'($urandom_range(1, 15)), -1, 0, $urandom_range(40));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
